// File: rtl/var_delay_pipe.sv
// var_delay_pipe
//   Variable-latency data pipe. MAX_DELAY registered stages, each holding a
//   data word and a valid bit, shift in lockstep. The output is tapped from
//   the stage selected by the active delay (cur_delay). With a delay of 0
//   the block is a combinational pass-through.
//
//   The delay can be changed at run time through dsel/dsel_load. A change is
//   only adopted when nothing is in flight (or when the same cycle flushes
//   the pipe). Otherwise it is refused and load_err is latched until reset.
//
// Ports
//   clk        clock, single domain
//   rst        synchronous active-high reset
//   x          input data
//   x_valid    input data qualifier
//   stall      freeze all stages for this cycle
//   flush      discard every in-flight item
//   dsel       requested delay (clamped to MAX_DELAY)
//   dsel_load  request to adopt dsel
//   y          delayed data
//   y_valid    delayed data qualifier
//   cur_delay  active delay
//   occ        number of valid items inside the active part of the pipe
//   load_err   sticky: a delay load was refused
module var_delay_pipe #(
  parameter  int WIDTH      = 32,
  parameter  int MAX_DELAY  = 8,
  parameter  int INIT_DELAY = 3,
  localparam int DW         = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             x_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [DW-1:0]    dsel,
  input  logic             dsel_load,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [DW-1:0]    cur_delay,
  output logic [DW-1:0]    occ,
  output logic             load_err
);

  // Requested delays above the physical depth saturate to the deepest tap.
  function automatic logic [DW-1:0] sat_delay(input logic [DW-1:0] d);
    if (int'(d) > MAX_DELAY) return DW'(MAX_DELAY);
    return d;
  endfunction

  logic [WIDTH-1:0] data_p [MAX_DELAY];
  logic             vld_p  [MAX_DELAY];

  logic [WIDTH-1:0] tail_data;
  logic             tail_vld;
  logic             dly_zero;
  logic             accept;
  logic             occ_inc;
  logic             occ_dec;
  logic             load_ok;
  logic             load_bad;

  assign dly_zero = (cur_delay == '0);
  assign accept   = x_valid & ~stall & ~flush;

  // Output tap: stage cur_delay-1. Written as a compare-select over all
  // stages so a zero delay never produces an out-of-range index.
  always_comb begin
    tail_data = '0;
    tail_vld  = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (cur_delay == DW'(i + 1)) begin
        tail_data = data_p[i];
        tail_vld  = vld_p[i];
      end
    end
  end

  // A flush in the same cycle empties the pipe and blocks acceptance, so the
  // load is judged against that emptied state and always succeeds.
  assign load_ok  = dsel_load & (flush | ((occ == '0) & (~x_valid | stall)));
  assign load_bad = dsel_load & ~load_ok;

  assign occ_inc = accept & ~dly_zero;
  assign occ_dec = tail_vld & ~stall & ~flush;

  assign y       = dly_zero ? x : tail_data;
  assign y_valid = (dly_zero ? x_valid : tail_vld) & ~stall & ~flush;

  // ---- stage registers: shift, hold on stall, clear on flush/reset ----
  // Stages past the active tap keep shifting; their valid bits are cleared
  // on every accepted load so a longer new delay never exposes stale items.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_p[i] <= '0;
        vld_p[i]  <= 1'b0;
      end
    end else begin
      if (!stall) begin
        data_p[0] <= x;
        for (int i = 1; i < MAX_DELAY; i++) data_p[i] <= data_p[i-1];
      end
      if (load_ok) begin
        for (int i = 0; i < MAX_DELAY; i++) vld_p[i] <= 1'b0;
      end else if (!stall) begin
        vld_p[0] <= x_valid;
        for (int i = 1; i < MAX_DELAY; i++) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // ---- control: occupancy, active delay, load error ----
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      cur_delay <= DW'(INIT_DELAY);
      load_err  <= 1'b0;
    end else begin
      if (flush || load_ok)       occ <= '0;
      else if (occ_inc && !occ_dec) occ <= occ + DW'(1);
      else if (occ_dec && !occ_inc) occ <= occ - DW'(1);

      if (load_ok)  cur_delay <= sat_delay(dsel);
      if (load_bad) load_err  <= 1'b1;
    end
  end

endmodule
